// File: rtl/fsm_sequence_monitor.sv
// Checks the state-code stream of the 4-state control FSM and counts completed loops.
// Optional idle watchdog in TRACK is compiled in with `define SEQ_MON_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | after reset/clear, nothing accepted yet
//  ALIGN | waiting for code 1 to resynchronise
//  TRACK | locked, checking every transition
module fsm_sequence_monitor #(
   parameter int CNT_W      = 8,
   parameter int ERR_W      = 4,
   parameter int ALLOW_HOLD = 0,
   parameter int TIMEOUT    = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Valid,
   input  logic [2:0]       Code,
   input  logic             Clear,
   output logic             Locked,
   output logic             Error,
   output logic [ERR_W-1:0] ErrCount,
   output logic [CNT_W-1:0] LoopCount,
   output logic [CNT_W-1:0] LongLoops,
   output logic [CNT_W-1:0] ShortLoops,
   output logic [2:0]       LastCode,
   output logic             Timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, TRACK = 2'd2} state_t;

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("fsm_sequence_monitor: TIMEOUT must be at least 2");
   end

   state_t           state_q;
   logic [2:0]       prev_q;
   logic             saw3_q;
   logic             error_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic [ERR_W-1:0] err_cnt_d;
   logic [CNT_W-1:0] loop_cnt_q;
   logic [CNT_W-1:0] long_cnt_q;
   logic [CNT_W-1:0] short_cnt_q;
   logic [2:0]       last_code_q;

   logic code_legal;
   logic step_ok;
   logic hold_ok;
   logic track_err;
   logic wd_fire;
   logic err_evt;

`ifdef SEQ_MON_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q;
   logic            timeout_q;
`endif

   always_comb begin
      code_legal = (Code >= 3'd1) && (Code <= 3'd4);
      hold_ok    = (ALLOW_HOLD != 0) && (Code == prev_q);
      case ({prev_q, Code})
         {3'd1, 3'd2}, {3'd2, 3'd3}, {3'd2, 3'd4},
         {3'd3, 3'd4}, {3'd4, 3'd1}: step_ok = 1'b1;
         default:                    step_ok = 1'b0;
      endcase
      track_err = Valid && (state_q == TRACK) && code_legal && !step_ok && !hold_ok;
`ifdef SEQ_MON_TIMEOUT_EN
      wd_fire = !Valid && (state_q == TRACK) && (wd_q == WD_W'(TIMEOUT - 1));
`else
      wd_fire = 1'b0;
`endif
      err_evt   = (Valid && !code_legal) || track_err || wd_fire;
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         saw3_q      <= 1'b0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
         loop_cnt_q  <= '0;
         long_cnt_q  <= '0;
         short_cnt_q <= '0;
         last_code_q <= '0;
`ifdef SEQ_MON_TIMEOUT_EN
         wd_q        <= '0;
         timeout_q   <= 1'b0;
`endif
      end else if (Clear) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         saw3_q      <= 1'b0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
         loop_cnt_q  <= '0;
         long_cnt_q  <= '0;
         short_cnt_q <= '0;
         last_code_q <= '0;
`ifdef SEQ_MON_TIMEOUT_EN
         wd_q        <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         if (err_evt) begin
            error_q   <= 1'b1;
            err_cnt_q <= err_cnt_d;
         end
         if (Valid) begin
            last_code_q <= Code;
            if (!code_legal) begin
               if (state_q != IDLE) state_q <= ALIGN;
            end else begin
               case (state_q)
                  IDLE, ALIGN: begin
                     if (Code == 3'd1) begin
                        state_q <= TRACK;
                        prev_q  <= 3'd1;
                        saw3_q  <= 1'b0;
                     end else begin
                        state_q <= ALIGN;
                     end
                  end
                  TRACK: begin
                     if (step_ok) begin
                        prev_q <= Code;
                        if (Code == 3'd3) saw3_q <= 1'b1;
                        // 4->1 closes a loop; classify by whether code 3 was seen
                        if (prev_q == 3'd4) begin
                           loop_cnt_q <= loop_cnt_q + 1'b1;
                           if (saw3_q) long_cnt_q  <= long_cnt_q + 1'b1;
                           else        short_cnt_q <= short_cnt_q + 1'b1;
                           saw3_q <= 1'b0;
                        end
                     end else if (track_err) begin
                        state_q <= ALIGN;
                     end
                  end
                  default: state_q <= IDLE;
               endcase
            end
         end
`ifdef SEQ_MON_TIMEOUT_EN
         if ((state_q == TRACK) && !Valid) begin
            if (wd_fire) begin
               timeout_q <= 1'b1;
               state_q   <= ALIGN;
               wd_q      <= '0;
            end else begin
               wd_q <= wd_q + 1'b1;
            end
         end else begin
            wd_q <= '0;
         end
`endif
      end
   end

   assign Locked     = (state_q == TRACK);
   assign Error      = error_q;
   assign ErrCount   = err_cnt_q;
   assign LoopCount  = loop_cnt_q;
   assign LongLoops  = long_cnt_q;
   assign ShortLoops = short_cnt_q;
   assign LastCode   = last_code_q;
`ifdef SEQ_MON_TIMEOUT_EN
   assign Timeout    = timeout_q;
`else
   assign Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_sequence_monitor.sv
// Bench for fsm_sequence_monitor: reference model feeds a scoreboard queue, plus directed checks.
module tb_fsm_sequence_monitor;

   localparam int TMO = 16;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Valid = 1'b0;
   logic [2:0] Code  = 3'd0;
   logic       Clear = 1'b0;

   logic       Locked, Error, Timeout;
   logic [3:0] ErrCount;
   logic [7:0] LoopCount, LongLoops, ShortLoops;
   logic [2:0] LastCode;

   logic       h_Locked, h_Error, h_Timeout;
   logic [3:0] h_ErrCount;
   logic [7:0] h_LoopCount, h_LongLoops, h_ShortLoops;
   logic [2:0] h_LastCode;

   int errors = 0;
   int checks = 0;

   fsm_sequence_monitor #(.CNT_W(8), .ERR_W(4), .ALLOW_HOLD(0), .TIMEOUT(TMO)) dut (
      .Clock(Clock), .Reset(Reset), .Valid(Valid), .Code(Code), .Clear(Clear),
      .Locked(Locked), .Error(Error), .ErrCount(ErrCount), .LoopCount(LoopCount),
      .LongLoops(LongLoops), .ShortLoops(ShortLoops), .LastCode(LastCode), .Timeout(Timeout));

   fsm_sequence_monitor #(.CNT_W(8), .ERR_W(4), .ALLOW_HOLD(1), .TIMEOUT(TMO)) dut_h (
      .Clock(Clock), .Reset(Reset), .Valid(Valid), .Code(Code), .Clear(Clear),
      .Locked(h_Locked), .Error(h_Error), .ErrCount(h_ErrCount), .LoopCount(h_LoopCount),
      .LongLoops(h_LongLoops), .ShortLoops(h_ShortLoops), .LastCode(h_LastCode),
      .Timeout(h_Timeout));

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic       locked;
      logic       error;
      logic [3:0] errcnt;
      logic [7:0] loops;
      logic [7:0] longl;
      logic [7:0] shortl;
      logic [2:0] last;
      logic       tmo;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e, mon_a;
   int   cyc = 0;

   // reference model of the ALLOW_HOLD=0 instance: 0=IDLE 1=ALIGN 2=TRACK
   int         m_state;
   logic [2:0] m_prev, m_last;
   logic       m_saw3, m_err, m_tmo;
   logic [3:0] m_errcnt;
   logic [7:0] m_loops, m_long, m_short;
   int         m_wd;

   task automatic model_clear();
      m_state = 0; m_prev = 0; m_last = 0; m_saw3 = 0; m_err = 0; m_tmo = 0;
      m_errcnt = 0; m_loops = 0; m_long = 0; m_short = 0; m_wd = 0;
   endtask

   task automatic model_error();
      m_err = 1'b1;
      if (m_errcnt != 4'hF) m_errcnt = m_errcnt + 4'd1;
   endtask

   task automatic model_step(input logic v, input logic [2:0] c, input logic clr);
      bit ok;
      if (clr) begin
         model_clear();
      end else if (v) begin
         m_last = c;
         m_wd = 0;
         if (c == 0 || c > 4) begin
            model_error();
            if (m_state != 0) m_state = 1;
         end else if (m_state != 2) begin
            if (c == 1) begin m_state = 2; m_prev = 1; m_saw3 = 0; end
            else m_state = 1;
         end else begin
            ok = (m_prev == 1 && c == 2) || (m_prev == 2 && (c == 3 || c == 4)) ||
                 (m_prev == 3 && c == 4) || (m_prev == 4 && c == 1);
            if (ok) begin
               if (c == 3) m_saw3 = 1;
               if (c == 1) begin
                  m_loops = m_loops + 8'd1;
                  if (m_saw3) m_long = m_long + 8'd1;
                  else m_short = m_short + 8'd1;
                  m_saw3 = 0;
               end
               m_prev = c;
            end else begin
               model_error();
               m_state = 1;
            end
         end
      end else begin
`ifdef SEQ_MON_TIMEOUT_EN
         if (m_state == 2) begin
            m_wd = m_wd + 1;
            if (m_wd == TMO) begin
               m_tmo = 1; m_state = 1; m_wd = 0;
               model_error();
            end
         end
`endif
      end
      sb_q.push_back({(m_state == 2), m_err, m_errcnt, m_loops, m_long, m_short,
                      m_last, m_tmo});
   endtask

   task automatic step(input logic v, input logic [2:0] c, input logic clr);
      @(negedge Clock);
      Valid = v; Code = c; Clear = clr;
      model_step(v, c, clr);
      @(posedge Clock);
      #2;
   endtask

   initial begin
      forever begin
         @(posedge Clock);
         #1;
         cyc++;
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            mon_a = {Locked, Error, ErrCount, LoopCount, LongLoops, ShortLoops,
                     LastCode, Timeout};
            checks++;
            if (mon_a !== mon_e) begin
               errors++;
               $display("FAIL scoreboard cyc=%0d got=%h exp=%h", cyc, mon_a, mon_e);
            end
         end
      end
   end

   task automatic test_reset();
      Reset = 1'b1;
      model_clear();
      #12;
      checks++;
      if ({Locked, Error, ErrCount, LoopCount, LongLoops, ShortLoops, LastCode, Timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {Locked, Error, ErrCount, LoopCount, LongLoops, ShortLoops, LastCode, Timeout});
      end
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic test_loops();
      logic [2:0] seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd4, 3'd1};
      for (int i = 0; i < 8; i++) begin
         step(1, seq[i], 0);
         checks++;
         if (Locked !== 1'b1) begin
            errors++;
            $display("FAIL loops_locked idx=%0d got=%b exp=1", i, Locked);
         end
      end
      checks++;
      if ({LoopCount, LongLoops, ShortLoops, Error} !== {8'd2, 8'd1, 8'd1, 1'b0}) begin
         errors++;
         $display("FAIL loops_counts got=%0d/%0d/%0d err=%b exp=2/1/1 err=0",
                  LoopCount, LongLoops, ShortLoops, Error);
      end
   endtask

   task automatic test_align();
      step(0, 0, 1);
      step(1, 3, 0);
      step(1, 4, 0);
      checks++;
      if (Locked !== 1'b0 || Error !== 1'b0) begin
         errors++;
         $display("FAIL align_wait got locked=%b err=%b exp locked=0 err=0", Locked, Error);
      end
      step(1, 1, 0);
      step(1, 2, 0);
      checks++;
      if (Locked !== 1'b1 || LoopCount !== 8'd0 || Error !== 1'b0) begin
         errors++;
         $display("FAIL align_lock got locked=%b loops=%0d err=%b exp 1 0 0",
                  Locked, LoopCount, Error);
      end
   endtask

   task automatic test_bad_transition();
      step(0, 0, 1);
      step(1, 1, 0);
      step(1, 3, 0);
      checks++;
      if (Error !== 1'b1 || ErrCount !== 4'd1 || Locked !== 1'b0) begin
         errors++;
         $display("FAIL bad_trans got err=%b cnt=%0d locked=%b exp 1 1 0",
                  Error, ErrCount, Locked);
      end
      step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 4, 0); step(1, 1, 0);
      checks++;
      if (LoopCount !== 8'd1 || LongLoops !== 8'd1 || Error !== 1'b1) begin
         errors++;
         $display("FAIL bad_trans_recover got loops=%0d long=%0d err=%b exp 1 1 1",
                  LoopCount, LongLoops, Error);
      end
   endtask

   task automatic test_saturation();
      logic [2:0] ill [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
      step(0, 0, 1);
      step(1, 7, 0);
      checks++;
      if (LastCode !== 3'd7 || ErrCount !== 4'd1) begin
         errors++;
         $display("FAIL sat_first got last=%0d cnt=%0d exp 7 1", LastCode, ErrCount);
      end
      for (int i = 0; i < 17; i++) step(1, ill[$urandom_range(0, 3)], 0);
      checks++;
      if (ErrCount !== 4'hF || Error !== 1'b1) begin
         errors++;
         $display("FAIL sat_final got cnt=%0d err=%b exp 15 1", ErrCount, Error);
      end
   endtask

   task automatic test_hold();
      step(0, 0, 1);
      step(1, 1, 0);
      step(1, 1, 0);
      checks++;
      if (Error !== 1'b1 || Locked !== 1'b0) begin
         errors++;
         $display("FAIL hold0 got err=%b locked=%b exp 1 0", Error, Locked);
      end
      step(1, 2, 0);
      checks++;
      if (h_Error !== 1'b0 || h_Locked !== 1'b1 || h_LastCode !== 3'd2) begin
         errors++;
         $display("FAIL hold1 got err=%b locked=%b last=%0d exp 0 1 2",
                  h_Error, h_Locked, h_LastCode);
      end
   endtask

   task automatic test_clear();
      step(0, 0, 1);
      step(1, 0, 0);
      step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 4, 0); step(1, 1, 0); step(1, 2, 0);
      checks++;
      if (LoopCount !== 8'd1 || Error !== 1'b1 || Locked !== 1'b1) begin
         errors++;
         $display("FAIL clear_pre got loops=%0d err=%b locked=%b exp 1 1 1",
                  LoopCount, Error, Locked);
      end
      step(1, 1, 1);
      checks++;
      if ({Locked, Error, ErrCount, LoopCount, LongLoops, ShortLoops, LastCode} !== '0 ||
          h_Locked !== 1'b0) begin
         errors++;
         $display("FAIL clear_post got=%h h_locked=%b exp all zero",
                  {Locked, Error, ErrCount, LoopCount, LongLoops, ShortLoops, LastCode}, h_Locked);
      end
      step(1, 2, 0);
      checks++;
      if (Locked !== 1'b0 || Error !== 1'b0) begin
         errors++;
         $display("FAIL clear_idle got locked=%b err=%b exp 0 0", Locked, Error);
      end
   endtask

   task automatic test_timeout();
      step(0, 0, 1);
      step(1, 1, 0);
      for (int i = 0; i < TMO - 1; i++) step(0, 1, 0);
      checks++;
      if (Locked !== 1'b1 || Timeout !== 1'b0) begin
         errors++;
         $display("FAIL tmo_before got locked=%b tmo=%b exp 1 0", Locked, Timeout);
      end
      step(0, 1, 0);
      checks++;
`ifdef SEQ_MON_TIMEOUT_EN
      if (Timeout !== 1'b1 || Locked !== 1'b0 || ErrCount !== 4'd1) begin
         errors++;
         $display("FAIL tmo_fire got tmo=%b locked=%b cnt=%0d exp 1 0 1",
                  Timeout, Locked, ErrCount);
      end
`else
      if (Timeout !== 1'b0 || Locked !== 1'b1 || ErrCount !== 4'd0) begin
         errors++;
         $display("FAIL tmo_off got tmo=%b locked=%b cnt=%0d exp 0 1 0",
                  Timeout, Locked, ErrCount);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [2:0] w = 3'd4;
      logic [2:0] c;
      int r;
      step(0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            step(0, 0, 1);
         end else if (r < 18) begin
            step(0, 3'($urandom_range(0, 7)), 0);
         end else begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
               case (w)
                  3'd1:    c = 3'd2;
                  3'd2:    c = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd4;
                  3'd3:    c = 3'd4;
                  default: c = 3'd1;
               endcase
            end else if (r < 92) begin
               c = 3'($urandom_range(1, 4));
            end else begin
               c = 3'($urandom_range(0, 7));
            end
            if (c >= 3'd1 && c <= 3'd4) w = c;
            step(1, c, 0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_loops();
      test_align();
      test_bad_transition();
      test_saturation();
      test_hold();
      test_clear();
      test_timeout();
      test_back_to_back();
      @(negedge Clock);
      Valid = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got=%0d pending exp=0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
